// File: rtl/slave_in.sv
// Slave-side serial bus receiver: select decode, LSB-first deserialisation, memory write/read strobes.
// Strobes land 1 cycle after the completing bit; flow is governed by master_valid and approval_grant.
module slave_in #(
  parameter int                   SLAVE_LEN = 2,
  parameter int                   ADDR_LEN  = 12,
  parameter int                   DATA_LEN  = 8,
  parameter int                   BURST_LEN = 12,
  parameter logic [SLAVE_LEN-1:0] SLAVE_ID  = '0,
  parameter int                   WAIT_MAX  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 approval_grant,
  input  logic                 rx_slave_select,
  input  logic                 rx_address,
  input  logic                 rx_data,
  input  logic                 rx_burst_number,
  input  logic                 master_valid,
  input  logic                 write_en,
  input  logic                 read_en,
  output logic                 slave_ready,
  output logic [ADDR_LEN-1:0]  mem_addr,
  output logic [DATA_LEN-1:0]  mem_wdata,
  output logic                 mem_we,
  output logic                 mem_re,
  output logic [BURST_LEN-1:0] read_burst,
  output logic                 rx_done,
  output logic                 frame_error
);

  localparam logic [2:0] S_IDLE = 3'd0, S_SEL = 3'd1, S_WAIT = 3'd2,
                         S_WR   = 3'd3, S_RD  = 3'd4, S_DONE = 3'd5;
  localparam int SCW = $clog2(SLAVE_LEN + 1);
  localparam int ACW = $clog2(ADDR_LEN + 1);
  localparam int BCW = $clog2(BURST_LEN + 2);
  localparam int DCW = $clog2(DATA_LEN + 1);
  localparam int WCW = $clog2(WAIT_MAX + 1);

  logic [2:0]           state;
  logic [SLAVE_LEN-1:0] sel_sr;
  logic [SCW-1:0]       sel_cnt;
  logic [WCW-1:0]       wait_cnt;
  logic [ADDR_LEN-1:0]  addr_sr;
  logic [ACW-1:0]       addr_cnt;
  logic [BURST_LEN-1:0] burst_sr;
  logic [BCW-1:0]       burst_cnt;
  logic [DATA_LEN-1:0]  data_sr;
  logic [DCW-1:0]       data_cnt;
  logic [DATA_LEN-1:0]  buf0, buf1;
  logic [1:0]           buf_cnt;
  logic [BURST_LEN-1:0] wr_cnt;

  logic                 smp, addr_ok, burst_ok, word_vld, pop, wr_fin, overflow;
  logic [SLAVE_LEN-1:0] sel_n;
  logic [ADDR_LEN-1:0]  addr_n;
  logic [ACW-1:0]       addr_cnt_n;
  logic [BURST_LEN-1:0] burst_n, n_words, wr_cnt_n;
  logic [BCW-1:0]       burst_cnt_n;
  logic [DATA_LEN-1:0]  data_n, head;
  logic [DCW-1:0]       data_cnt_n;
  logic [1:0]           avail;

  // Next-cycle view of the deserialisers so a completing bit can strobe on the very next edge.
  always_comb begin
    sel_n       = {rx_slave_select, sel_sr[SLAVE_LEN-1:1]};
    smp         = master_valid && (state == S_WR || state == S_RD);
    addr_n      = addr_sr;
    addr_cnt_n  = addr_cnt;
    burst_n     = burst_sr;
    burst_cnt_n = burst_cnt;
    data_n      = data_sr;
    data_cnt_n  = data_cnt;
    word_vld    = 1'b0;
    if (smp && addr_cnt != ACW'(ADDR_LEN)) begin
      addr_n     = {rx_address, addr_sr[ADDR_LEN-1:1]};
      addr_cnt_n = addr_cnt + ACW'(1);
    end
    if (smp && burst_cnt != BCW'(BURST_LEN + 1)) begin
      burst_cnt_n = burst_cnt + BCW'(1);
      if (burst_cnt != '0)
        burst_n = {rx_burst_number, burst_sr[BURST_LEN-1:1]};
    end
    if (smp && state == S_WR) begin
      data_n = {rx_data, data_sr[DATA_LEN-1:1]};
      if (data_cnt == DCW'(DATA_LEN - 1)) begin
        data_cnt_n = '0;
        word_vld   = 1'b1;
      end else begin
        data_cnt_n = data_cnt + DCW'(1);
      end
    end
    addr_ok  = (addr_cnt_n == ACW'(ADDR_LEN));
    burst_ok = (burst_cnt_n == BCW'(BURST_LEN + 1));
    n_words  = (burst_n == '0) ? BURST_LEN'(1) : burst_n;
    avail    = buf_cnt + {1'b0, word_vld};
    head     = (buf_cnt != 2'd0) ? buf0 : data_n;
    pop      = (state == S_WR) && addr_ok && (avail != 2'd0) && !(burst_ok && wr_cnt == n_words);
    wr_cnt_n = wr_cnt + BURST_LEN'(pop);
    wr_fin   = burst_ok && (wr_cnt_n == n_words);
    overflow = (avail == 2'd3) && !addr_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;  sel_sr <= '0;  sel_cnt <= '0;  wait_cnt <= '0;
      addr_sr <= '0;  addr_cnt <= '0;  burst_sr <= '0;  burst_cnt <= '0;
      data_sr <= '0;  data_cnt <= '0;  buf0 <= '0;  buf1 <= '0;  buf_cnt <= '0;  wr_cnt <= '0;
      slave_ready <= 1'b0;  mem_addr <= '0;  mem_wdata <= '0;  read_burst <= '0;
      mem_we <= 1'b0;  mem_re <= 1'b0;  rx_done <= 1'b0;  frame_error <= 1'b0;
    end else begin
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      rx_done     <= 1'b0;
      frame_error <= 1'b0;
      addr_sr     <= addr_n;
      addr_cnt    <= addr_cnt_n;
      burst_sr    <= burst_n;
      burst_cnt   <= burst_cnt_n;
      data_sr     <= data_n;
      data_cnt    <= data_cnt_n;
      if (state != S_IDLE && (!approval_grant || overflow)) begin
        frame_error <= 1'b1;
        slave_ready <= 1'b0;
        state       <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            // Every frame starts from clean counters and an empty word buffer.
            sel_cnt <= '0;  wait_cnt <= '0;  addr_cnt <= '0;  burst_cnt <= '0;
            data_cnt <= '0;  buf_cnt <= '0;  wr_cnt <= '0;
            if (approval_grant && rx_slave_select) state <= S_SEL;
          end
          S_SEL: begin
            sel_sr <= sel_n;
            if (sel_cnt == SCW'(SLAVE_LEN - 1)) begin
              if (sel_n == SLAVE_ID) begin
                slave_ready <= 1'b1;
                state       <= S_WAIT;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              sel_cnt <= sel_cnt + SCW'(1);
            end
          end
          S_WAIT: begin
            if (write_en)      state <= S_WR;
            else if (read_en)  state <= S_RD;
            else if (wait_cnt == WCW'(WAIT_MAX - 1)) begin
              frame_error <= 1'b1;
              slave_ready <= 1'b0;
              state       <= S_IDLE;
            end else begin
              wait_cnt <= wait_cnt + WCW'(1);
            end
          end
          S_WR: begin
            case ({word_vld, pop})
              2'b10: begin
                if (buf_cnt == 2'd0) buf0 <= data_n;
                else                 buf1 <= data_n;
                buf_cnt <= buf_cnt + 2'd1;
              end
              2'b01: begin
                buf0    <= buf1;
                buf_cnt <= buf_cnt - 2'd1;
              end
              2'b11: begin
                if (buf_cnt == 2'd1) buf0 <= data_n;
                else if (buf_cnt == 2'd2) begin
                  buf0 <= buf1;
                  buf1 <= data_n;
                end
              end
              default: ;
            endcase
            if (pop) begin
              mem_we    <= 1'b1;
              mem_addr  <= addr_n + ADDR_LEN'(wr_cnt);
              mem_wdata <= head;
            end
            wr_cnt <= wr_cnt_n;
            if (wr_fin) state <= S_DONE;
          end
          S_RD: begin
            if (addr_ok && burst_ok) begin
              mem_re     <= 1'b1;
              mem_addr   <= addr_n;
              read_burst <= burst_n;
              state      <= S_DONE;
            end
          end
          S_DONE: begin
            rx_done     <= 1'b1;
            slave_ready <= 1'b0;
            state       <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_slave_in.sv
// Directed bench for slave_in: select decode, write/read frames, wrap, abort and reset cases.
module tb_slave_in;
  logic        clk = 1'b0;
  logic        reset, approval_grant, rx_slave_select, rx_address, rx_data, rx_burst_number;
  logic        master_valid, write_en, read_en;
  logic        slave_ready, mem_we, mem_re, rx_done, frame_error;
  logic [11:0] mem_addr, read_burst;
  logic [7:0]  mem_wdata;

  int vecs = 0, errs = 0;
  int we_cnt = 0, re_cnt = 0, done_cnt = 0, err_cnt = 0;
  logic [11:0] we_addr[$], re_addr[$], re_burst[$];
  logic [7:0]  we_data[$];

  slave_in #(.SLAVE_ID(2'd2)) dut (
    .clk(clk), .reset(reset), .approval_grant(approval_grant),
    .rx_slave_select(rx_slave_select), .rx_address(rx_address), .rx_data(rx_data),
    .rx_burst_number(rx_burst_number), .master_valid(master_valid),
    .write_en(write_en), .read_en(read_en), .slave_ready(slave_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .read_burst(read_burst), .rx_done(rx_done), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin we_cnt++; we_addr.push_back(mem_addr); we_data.push_back(mem_wdata); end
    if (mem_re) begin re_cnt++; re_addr.push_back(mem_addr); re_burst.push_back(read_burst); end
    if (rx_done) done_cnt++;
    if (frame_error) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic select(input logic [1:0] id);
    rx_slave_select = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      rx_slave_select = id[i];
      step();
    end
    rx_slave_select = 1'b0;
  endtask

  // Drives LSB-first fields; burst line carries a 0 marker before its 12 bits.
  task automatic send_fields(input logic [11:0] addr, input logic [11:0] burst,
                             input logic [23:0] words, input int nw, input int limit);
    int nsamp;
    nsamp = (8 * nw > 13) ? 8 * nw : 13;
    if (limit < nsamp) nsamp = limit;
    for (int i = 0; i < nsamp; i++) begin
      master_valid    = 1'b1;
      rx_address      = (i < 12) ? addr[i] : 1'b0;
      rx_burst_number = (i >= 1 && i <= 12) ? burst[i-1] : 1'b0;
      rx_data         = (i < 8 * nw) ? words[i] : 1'b0;
      step();
    end
    master_valid = 1'b0; rx_address = 1'b0; rx_burst_number = 1'b0; rx_data = 1'b0;
  endtask

  task automatic wait_end(input int base_d, input int base_e);
    int n = 0;
    while (done_cnt == base_d && err_cnt == base_e && n < 60) begin
      step();
      n++;
    end
    chk("frame_end_seen", 32'(done_cnt != base_d || err_cnt != base_e), 32'd1);
  endtask

  initial begin
    int bw, br, bd, be;
    reset = 1'b1; approval_grant = 1'b0; rx_slave_select = 1'b0; rx_address = 1'b0;
    rx_data = 1'b0; rx_burst_number = 1'b0; master_valid = 1'b0; write_en = 1'b0; read_en = 1'b0;
    repeat (3) step();
    chk("reset_flags", {slave_ready, mem_we, mem_re, rx_done, frame_error}, 32'd0);
    chk("reset_bus", {mem_addr, read_burst, mem_wdata}, 32'd0);
    reset = 1'b0; approval_grant = 1'b1;
    step();

    // Matching id then idle command window: timeout exactly on the WAIT_MAX-th idle cycle.
    be = err_cnt;
    select(2'b10);
    chk("sel_match_ready", slave_ready, 1);
    repeat (9) step();
    chk("wait_9_ready", slave_ready, 1);
    chk("wait_9_noerr", frame_error, 0);
    step();
    chk("wait_timeout_err", frame_error, 1);
    chk("wait_timeout_ready", slave_ready, 0);
    step();

    // Non-matching id: silent return.
    bw = we_cnt; br = re_cnt; be = err_cnt;
    select(2'b01);
    chk("sel_miss_ready", slave_ready, 0);
    repeat (4) step();
    chk("sel_miss_ready_late", slave_ready, 0);
    chk("sel_miss_strobes", 32'((we_cnt - bw) + (re_cnt - br) + (err_cnt - be)), 0);

    // Single write, burst 0; write_en wins over read_en.
    bw = we_cnt; br = re_cnt; bd = done_cnt; be = err_cnt;
    select(2'b10);
    write_en = 1'b1; read_en = 1'b1; step(); write_en = 1'b0; read_en = 1'b0;
    send_fields(12'h0A5, 12'd0, 24'h00003C, 1, 100);
    wait_end(bd, be);
    step();
    chk("wr1_we_count", 32'(we_cnt - bw), 1);
    chk("wr1_addr", we_addr[bw], 12'h0A5);
    chk("wr1_data", we_data[bw], 8'h3C);
    chk("wr1_done", 32'(done_cnt - bd), 1);
    chk("wr1_no_re", 32'(re_cnt - br), 0);
    chk("wr1_ready_low", slave_ready, 0);

    // Burst 3 with address wrap.
    bw = we_cnt; bd = done_cnt; be = err_cnt;
    select(2'b10);
    write_en = 1'b1; step(); write_en = 1'b0;
    send_fields(12'hFFF, 12'd3, 24'h332211, 3, 100);
    wait_end(bd, be);
    step();
    chk("wr3_we_count", 32'(we_cnt - bw), 3);
    chk("wr3_addr0", we_addr[bw], 12'hFFF);
    chk("wr3_addr1", we_addr[bw+1], 12'h000);
    chk("wr3_addr2", we_addr[bw+2], 12'h001);
    chk("wr3_data0", we_data[bw], 8'h11);
    chk("wr3_data1", we_data[bw+1], 8'h22);
    chk("wr3_data2", we_data[bw+2], 8'h33);
    chk("wr3_done", 32'(done_cnt - bd), 1);
    chk("wr3_no_err", 32'(err_cnt - be), 0);

    // Read request.
    bw = we_cnt; br = re_cnt; bd = done_cnt; be = err_cnt;
    select(2'b10);
    read_en = 1'b1; step(); read_en = 1'b0;
    send_fields(12'h123, 12'd4, 24'h0, 0, 100);
    wait_end(bd, be);
    step();
    chk("rd_re_count", 32'(re_cnt - br), 1);
    chk("rd_addr", re_addr[br], 12'h123);
    chk("rd_burst", re_burst[br], 12'd4);
    chk("rd_done", 32'(done_cnt - bd), 1);
    chk("rd_no_we", 32'(we_cnt - bw), 0);

    // Grant lost after 5 address bits.
    bw = we_cnt; br = re_cnt; bd = done_cnt; be = err_cnt;
    select(2'b10);
    write_en = 1'b1; step(); write_en = 1'b0;
    send_fields(12'h5A5, 12'd1, 24'h0000FF, 1, 5);
    approval_grant = 1'b0;
    step();
    chk("grant_err_pulse", frame_error, 1);
    chk("grant_ready_low", slave_ready, 0);
    approval_grant = 1'b1;
    repeat (3) step();
    chk("grant_err_count", 32'(err_cnt - be), 1);
    chk("grant_no_strobes", 32'((we_cnt - bw) + (re_cnt - br) + (done_cnt - bd)), 0);

    // Reset in the middle of a write frame.
    bw = we_cnt;
    select(2'b10);
    write_en = 1'b1; step(); write_en = 1'b0;
    send_fields(12'h0F0, 12'd2, 24'h00AA55, 2, 10);
    reset = 1'b1;
    step();
    chk("midrst_flags", {slave_ready, mem_we, mem_re, rx_done, frame_error}, 32'd0);
    chk("midrst_bus", {mem_addr, read_burst, mem_wdata}, 32'd0);
    reset = 1'b0;
    repeat (5) step();
    chk("midrst_no_we", 32'(we_cnt - bw), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end
endmodule
